// File: rtl/pe_pkg.sv
// Shared widths, pipeline depths and typedefs for the convolution PE.
package pe_pkg;

  localparam int DATA_W       = 30;
  localparam int WEIGHT_W     = 18;
  localparam int ACC_W        = 48;
  localparam int PE_LATENCY   = 3;
  localparam int RELU_LATENCY = 1;

  typedef logic signed [DATA_W-1:0]   pix_t;
  typedef logic signed [WEIGHT_W-1:0] wgt_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  // Output side length of a square convolution.
  function automatic int out_side(input int n, input int k, input int p, input int s);
    return (n - k + 2 * p) / s + 1;
  endfunction

endpackage

// File: rtl/relu_stage.sv
// Registered rectifier: o_data = max(i_data, 0), captured on i_en, held otherwise.
// One cycle latency; no backpressure, o_en simply follows i_en.
module relu_stage
  import pe_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [ACC_W-1:0] i_data,
  output logic             o_en,
  output logic [ACC_W-1:0] o_data
);

  logic             r_en;
  logic [ACC_W-1:0] r_data;

  generate
    if (RELU_LATENCY != 1) begin : g_err_lat
      $error("relu_stage implements exactly one register stage");
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en   <= 1'b0;
      r_data <= '0;
    end else begin
      r_en <= i_en;
      if (i_en) begin
        r_data <= i_data[ACC_W-1] ? '0 : i_data;
      end
    end
  end

  assign o_en   = r_en;
  assign o_data = r_data;

endmodule

// File: rtl/pe_relu.sv
// Streaming KxK convolution PE + ReLU; o_conv_en 3 cycles after the bottom-right pixel, o_en 1 later.
// No backpressure: i_en=0 freezes the input side while results drain. PE_SAT_EN saturates the sum.
module pe_relu
  import pe_pkg::*;
#(
  parameter int KERNEL_SIZE = 1,
  parameter int FM_SIZE     = 2,
  parameter int PADDING     = 0,
  parameter int STRIDE      = 1
)(
  input  logic                                       i_clk,
  input  logic                                       i_rst_n,
  input  logic [DATA_W-1:0]                          i_DataFM,
  input  logic                                       i_en,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*WEIGHT_W-1:0] i_Weight,
  output logic                                       o_conv_en,
  output logic [ACC_W-1:0]                           o_conv,
  output logic                                       o_en,
  output logic [ACC_W-1:0]                           o_data
);

  localparam int K        = KERNEL_SIZE;
  localparam int N        = FM_SIZE;
  localparam int S        = STRIDE;
  localparam int TAPS     = K * K;
  localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam int OUT_SIDE = out_side(N, K, PADDING, S);
`ifdef PE_SAT_EN
  localparam int SUM_W    = ACC_W + $clog2(TAPS);
`else
  localparam int SUM_W    = ACC_W;
`endif

  generate
    if (PADDING != 0) begin : g_err_pad
      $error("pe_relu: only PADDING=0 is supported");
    end
    if (K < 1 || K > 5 || N < K || S < 1 || OUT_SIDE < 1) begin : g_err_geom
      $error("pe_relu: illegal KERNEL_SIZE/FM_SIZE/STRIDE combination");
    end
  endgenerate

  logic [CNT_W-1:0]        r_row;
  logic [CNT_W-1:0]        r_col;
  int                      w_row_off;
  int                      w_col_off;
  logic                    w_win_pos;
  logic                    r_in_vld;
  logic                    r_in_win;
  pix_t                    r_in_dat;
  pix_t                    w_col_in [K];
  pix_t                    r_win    [K][K];
  wgt_t                    w_wgt    [TAPS];
  acc_t                    r_prod   [TAPS];
  logic signed [SUM_W-1:0] w_sum;
  acc_t                    w_sat;
  acc_t                    r_sum;
  logic [PE_LATENCY-1:0]   r_vld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_en) begin
      if (r_col == CNT_W'(N - 1)) begin
        r_col <= '0;
        r_row <= (r_row == CNT_W'(N - 1)) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // The pixel being sampled closes a window when it sits on the stride grid past the first K-1 rows/cols.
  assign w_row_off = int'(r_row) - (K - 1);
  assign w_col_off = int'(r_col) - (K - 1);
  assign w_win_pos = (w_row_off >= 0) && (w_col_off >= 0) &&
                     ((w_row_off % S) == 0) && ((w_col_off % S) == 0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_vld <= 1'b0;
      r_in_win <= 1'b0;
      r_in_dat <= '0;
    end else begin
      r_in_vld <= i_en;
      r_in_win <= i_en & w_win_pos;
      if (i_en) begin
        r_in_dat <= i_DataFM;
      end
    end
  end

  generate
    if (K > 1) begin : g_lb
      pix_t r_lb [K-1][N];

      // Line j replays the pixel j+1 rows above the current one at the same column.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int j = 0; j < K - 1; j++) begin
            for (int i = 0; i < N; i++) begin
              r_lb[j][i] <= '0;
            end
          end
        end else if (r_in_vld) begin
          for (int j = 0; j < K - 1; j++) begin
            for (int i = N - 1; i > 0; i--) begin
              r_lb[j][i] <= r_lb[j][i-1];
            end
          end
          r_lb[0][0] <= r_in_dat;
          for (int j = 1; j < K - 1; j++) begin
            r_lb[j][0] <= r_lb[j-1][N-1];
          end
        end
      end

      for (genvar r = 0; r < K - 1; r++) begin : g_tap
        assign w_col_in[r] = r_lb[K-2-r][N-1];
      end
    end
  endgenerate

  assign w_col_in[K-1] = r_in_dat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (r_in_vld) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          r_win[r][c] <= r_win[r][c+1];
        end
        r_win[r][K-1] <= w_col_in[r];
      end
    end
  end

  generate
    for (genvar t = 0; t < TAPS; t++) begin : g_wgt
      assign w_wgt[t] = i_Weight[WEIGHT_W*t +: WEIGHT_W];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int t = 0; t < TAPS; t++) begin
        r_prod[t] <= '0;
      end
    end else if (r_vld[0]) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          r_prod[r*K+c] <= acc_t'(r_win[r][c]) * acc_t'(w_wgt[r*K+c]);
        end
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int t = 0; t < TAPS; t++) begin
      w_sum = w_sum + SUM_W'(r_prod[t]);
    end
  end

`ifdef PE_SAT_EN
  localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'({1'b0, {(ACC_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] SUM_MIN = ~SUM_MAX;

  always_comb begin
    if (w_sum > SUM_MAX) begin
      w_sat = {1'b0, {(ACC_W-1){1'b1}}};
    end else if (w_sum < SUM_MIN) begin
      w_sat = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      w_sat = w_sum[ACC_W-1:0];
    end
  end
`else
  assign w_sat = w_sum;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      r_sum <= '0;
    end else begin
      r_vld <= {r_vld[PE_LATENCY-2:0], r_in_win};
      if (r_vld[PE_LATENCY-2]) begin
        r_sum <= w_sat;
      end
    end
  end

  assign o_conv_en = r_vld[PE_LATENCY-1];
  assign o_conv    = r_sum;

  relu_stage u_relu (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (r_vld[PE_LATENCY-1]),
    .i_data  (r_sum),
    .o_en    (o_en),
    .o_data  (o_data)
  );

endmodule

// File: tb/tb_pe_relu.sv
// Bench for pe_relu: four instances of different geometry, scoreboard of expected results with arrival cycles.
module tb_pe_relu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en   [4];
  logic [29:0] dat  [4];
  logic [17:0] w0;
  logic [71:0] w1;
  logic [161:0] w2;
  logic [71:0] w3;
  logic        oce  [4];
  logic [47:0] oc   [4];
  logic        oe   [4];
  logic [47:0] od   [4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt [4];
  int relu_cnt  [4];
  int fm [25];
  int wt [25];

  typedef struct {
    int                 id;
    logic signed [47:0] val;
    int                 cyc;
  } exp_t;

  exp_t conv_q[$];
  exp_t relu_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pe_relu #(.KERNEL_SIZE(1), .FM_SIZE(2), .PADDING(0), .STRIDE(1)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_DataFM(dat[0]), .i_en(en[0]), .i_Weight(w0),
    .o_conv_en(oce[0]), .o_conv(oc[0]), .o_en(oe[0]), .o_data(od[0]));
  pe_relu #(.KERNEL_SIZE(2), .FM_SIZE(3), .PADDING(0), .STRIDE(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_DataFM(dat[1]), .i_en(en[1]), .i_Weight(w1),
    .o_conv_en(oce[1]), .o_conv(oc[1]), .o_en(oe[1]), .o_data(od[1]));
  pe_relu #(.KERNEL_SIZE(3), .FM_SIZE(3), .PADDING(0), .STRIDE(1)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_DataFM(dat[2]), .i_en(en[2]), .i_Weight(w2),
    .o_conv_en(oce[2]), .o_conv(oc[2]), .o_en(oe[2]), .o_data(od[2]));
  pe_relu #(.KERNEL_SIZE(2), .FM_SIZE(4), .PADDING(0), .STRIDE(2)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_DataFM(dat[3]), .i_en(en[3]), .i_Weight(w3),
    .o_conv_en(oce[3]), .o_conv(oc[3]), .o_en(oe[3]), .o_data(od[3]));

  function automatic int kk(input int id);
    case (id)
      0: return 1;
      1: return 2;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int nn(input int id);
    case (id)
      0: return 2;
      1: return 3;
      2: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int ss(input int id);
    return (id == 3) ? 2 : 1;
  endfunction

  // Direct evaluation of the window sum ending at (row,col).
  function automatic logic signed [47:0] ref_conv(input int id, input int row, input int col);
    longint acc;
    int     k;
    int     n;
    k   = kk(id);
    n   = nn(id);
    acc = 0;
    for (int r = 0; r < k; r++) begin
      for (int c = 0; c < k; c++) begin
        acc += longint'(wt[r*k+c]) * longint'(fm[(row-k+1+r)*n + (col-k+1+c)]);
      end
    end
`ifdef PE_SAT_EN
    if (acc > 64'sh0000_7FFF_FFFF_FFFF) acc = 64'sh0000_7FFF_FFFF_FFFF;
    if (acc < -64'sh0000_8000_0000_0000) acc = -64'sh0000_8000_0000_0000;
`endif
    return acc[47:0];
  endfunction

  task automatic load_weights(input int id);
    logic [449:0] wb;
    wb = '0;
    for (int i = 0; i < kk(id) * kk(id); i++) wb[18*i +: 18] = 18'(wt[i]);
    case (id)
      0: w0 = wb[17:0];
      1: w1 = wb[71:0];
      2: w2 = wb[161:0];
      default: w3 = wb[71:0];
    endcase
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin
      pulse_cnt[i] = 0;
      relu_cnt[i]  = 0;
    end
  endtask

  task automatic drive_frame(input int id, input int stall_after, input int stall_len);
    int k;
    int n;
    int s;
    int row;
    int col;
    exp_t e;
    logic signed [47:0] v;
    k = kk(id);
    n = nn(id);
    s = ss(id);
    for (int p = 0; p < n * n; p++) begin
      @(posedge clk);
      #1;
      en[id]  = 1'b1;
      dat[id] = 30'(fm[p]);
      row = p / n;
      col = p % n;
      if (row >= k - 1 && col >= k - 1 && ((row - k + 1) % s) == 0 && ((col - k + 1) % s) == 0) begin
        v     = ref_conv(id, row, col);
        e.id  = id;
        e.val = v;
        e.cyc = cyc + 4;
        conv_q.push_back(e);
        e.val = v[47] ? 48'sd0 : v;
        e.cyc = cyc + 5;
        relu_q.push_back(e);
      end
      if (p == stall_after) begin
        repeat (stall_len) begin
          @(posedge clk);
          #1;
          en[id] = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) en[i] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (oce[i] === 1'b1) begin
          pulse_cnt[i]++;
          checks++;
          if (conv_q.size() == 0) begin
            errors++;
            $display("FAIL conv_unexpected inst=%0d got=%0d cyc=%0d required=no pulse", i, $signed(oc[i]), cyc);
          end else begin
            e = conv_q.pop_front();
            if (e.id != i || oc[i] !== e.val || cyc != e.cyc) begin
              errors++;
              $display("FAIL conv inst=%0d got=%0d@%0d required inst=%0d %0d@%0d",
                       i, $signed(oc[i]), cyc, e.id, e.val, e.cyc);
            end
          end
        end
        if (oe[i] === 1'b1) begin
          relu_cnt[i]++;
          checks++;
          if (relu_q.size() == 0) begin
            errors++;
            $display("FAIL relu_unexpected inst=%0d got=%0d cyc=%0d required=no pulse", i, $signed(od[i]), cyc);
          end else begin
            e = relu_q.pop_front();
            if (e.id != i || od[i] !== e.val || cyc != e.cyc) begin
              errors++;
              $display("FAIL relu inst=%0d got=%0d@%0d required inst=%0d %0d@%0d",
                       i, $signed(od[i]), cyc, e.id, e.val, e.cyc);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en[i]  = 1'b0;
      dat[i] = '0;
    end
    w0 = '0; w1 = '0; w2 = '0; w3 = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({oce[i], oe[i]} !== 2'b00 || oc[i] !== 48'd0 || od[i] !== 48'd0) begin
        errors++;
        $display("FAIL reset_outputs inst=%0d got en=%b/%b conv=%h data=%h required all zero",
                 i, oce[i], oe[i], oc[i], od[i]);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_k1();
    clear_counts();
    fm[0] = 1; fm[1] = 2; fm[2] = -10; fm[3] = 4;
    wt[0] = 1;
    load_weights(0);
    drive_frame(0, -1, 0);
    idle(8);
    checks++;
    if (pulse_cnt[0] != 4 || relu_cnt[0] != 4 || conv_q.size() != 0 || relu_q.size() != 0) begin
      errors++;
      $display("FAIL k1_count got conv=%0d relu=%0d required 4/4", pulse_cnt[0], relu_cnt[0]);
    end
  endtask

  task automatic test_k2();
    clear_counts();
    for (int i = 0; i < 9; i++) fm[i] = i + 1;
    for (int i = 0; i < 4; i++) wt[i] = 1;
    load_weights(1);
    drive_frame(1, -1, 0);
    idle(8);
    checks++;
    if (pulse_cnt[1] != 4 || relu_cnt[1] != 4 || conv_q.size() != 0 || relu_q.size() != 0) begin
      errors++;
      $display("FAIL k2_count got conv=%0d relu=%0d required 4/4", pulse_cnt[1], relu_cnt[1]);
    end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    for (int i = 0; i < 9; i++) fm[i] = i + 1;
    for (int i = 0; i < 9; i++) wt[i] = 1;
    load_weights(2);
    drive_frame(2, -1, 0);
    drive_frame(2, -1, 0);
    idle(8);
    checks++;
    if (pulse_cnt[2] != 2 || relu_cnt[2] != 2 || conv_q.size() != 0 || relu_q.size() != 0) begin
      errors++;
      $display("FAIL k3_count got conv=%0d relu=%0d required 2/2", pulse_cnt[2], relu_cnt[2]);
    end
  endtask

  task automatic test_stride();
    clear_counts();
    for (int i = 0; i < 16; i++) fm[i] = i + 1;
    for (int i = 0; i < 4; i++) wt[i] = 1;
    load_weights(3);
    drive_frame(3, -1, 0);
    idle(8);
    checks++;
    if (pulse_cnt[3] != 4 || relu_cnt[3] != 4 || conv_q.size() != 0 || relu_q.size() != 0) begin
      errors++;
      $display("FAIL stride_count got conv=%0d relu=%0d required 4/4", pulse_cnt[3], relu_cnt[3]);
    end
  endtask

  task automatic test_stall();
    clear_counts();
    for (int i = 0; i < 9; i++) fm[i] = i + 1;
    wt[0] = 1; wt[1] = -1; wt[2] = 2; wt[3] = 0;
    load_weights(1);
    drive_frame(1, 4, 3);
    idle(8);
    checks++;
    if (pulse_cnt[1] != 4 || relu_cnt[1] != 4 || conv_q.size() != 0 || relu_q.size() != 0) begin
      errors++;
      $display("FAIL stall_count got conv=%0d relu=%0d required 4/4", pulse_cnt[1], relu_cnt[1]);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_counts();
    for (int i = 0; i < 9; i++) fm[i] = i + 1;
    for (int i = 0; i < 4; i++) wt[i] = 1;
    load_weights(1);
    for (int p = 0; p < 5; p++) begin
      @(posedge clk);
      #1;
      en[1]  = 1'b1;
      dat[1] = 30'(fm[p]);
    end
    @(posedge clk);
    #1;
    en[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({oce[1], oe[1]} !== 2'b00 || oc[1] !== 48'd0 || od[1] !== 48'd0) begin
      errors++;
      $display("FAIL midreset_outputs got en=%b/%b conv=%h data=%h required all zero",
               oce[1], oe[1], oc[1], od[1]);
    end
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    checks++;
    if (pulse_cnt[1] != 0 || relu_cnt[1] != 0) begin
      errors++;
      $display("FAIL midreset_stale got conv=%0d relu=%0d required 0/0", pulse_cnt[1], relu_cnt[1]);
    end
    drive_frame(1, -1, 0);
    idle(8);
    checks++;
    if (pulse_cnt[1] != 4 || relu_cnt[1] != 4 || conv_q.size() != 0 || relu_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_count got conv=%0d relu=%0d required 4/4", pulse_cnt[1], relu_cnt[1]);
    end
  endtask

  task automatic test_wrap();
    clear_counts();
    for (int i = 0; i < 9; i++) fm[i] = -536870912;
    for (int i = 0; i < 4; i++) wt[i] = -131072;
    load_weights(1);
    drive_frame(1, -1, 0);
    idle(8);
    checks++;
    if (pulse_cnt[1] != 4 || relu_cnt[1] != 4 || conv_q.size() != 0 || relu_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_count got conv=%0d relu=%0d required 4/4", pulse_cnt[1], relu_cnt[1]);
    end
  endtask

  initial begin
    clear_counts();
    fork
      monitor();
    join_none
    test_reset();
    test_k1();
    test_k2();
    test_back_to_back();
    test_stride();
    test_stall();
    test_reset_mid_frame();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
